// File: rtl/usb_rst_sequencer.sv
// rtl/usb_rst_sequencer.sv - hardware-timed reset sequencer for the external USB host chip
//
// Purpose:
//   Drives the USB chip reset pin through timed phases: ASSERT (pin low for
//   ASSERT_LEN cycles), then RECOVER (pin high for RECOVER_LEN cycles),
//   then IDLE with done set. A stored software HOLD bit keeps the pin low
//   until it is cleared. Once HOLD is released, a fresh RECOVER phase runs.
//
// Optional feature:
//   Define USB_RST_IRQ_EN to add the irq output and the CTRL bit3 irq_en bit.
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   [1:0] register select (0 CTRL, 1 STATUS, 2 ASSERT_LEN, 3 RECOVER_LEN)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   [31:0] write data
//   readdata    out  [31:0] combinational read data for the current address
//   usb_rst_n   out  registered active-low reset to the USB chip
//   busy        out  registered, high whenever the sequencer is not IDLE
//   irq         out  registered done & irq_en (USB_RST_IRQ_EN only)

module usb_rst_sequencer #(
    parameter int CNT_W          = 24,
    parameter int ASSERT_CYCLES  = 50000,
    parameter int RECOVER_CYCLES = 500000,
    parameter int AUTO_ON_RESET  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        usb_rst_n,
`ifdef USB_RST_IRQ_EN
    output logic        irq,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RECOVER = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ASSERT_RST  = CNT_W'(ASSERT_CYCLES);
    localparam logic [CNT_W-1:0] RECOVER_RST = CNT_W'(RECOVER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam state_t           ST_RST      = (AUTO_ON_RESET != 0) ? ST_ASSERT : ST_IDLE;
    // Auto mode comes out of reset already inside the ASSERT phase.
    localparam logic [CNT_W-1:0] CNT_RST     = (AUTO_ON_RESET != 0 && ASSERT_CYCLES > 1)
                                               ? CNT_W'(ASSERT_CYCLES - 1) : '0;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hold;
    logic             r_done;
    logic [CNT_W-1:0] r_assert_len;
    logic [CNT_W-1:0] r_recover_len;
    logic             r_usb_rst_n;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_done_set;
    logic             w_wr;
    logic             w_wr_ctrl;
    logic             w_wr_status;
    logic             w_hold_nxt;
    logic             w_start;
    logic [CNT_W-1:0] w_assert_load;
    logic [CNT_W-1:0] w_recover_load;
    logic             w_irq_en_rd;
    logic [31:0]      w_assert_len_ext;
    logic [31:0]      w_recover_len_ext;
    logic             w_unused_wdata;

    assign w_wr        = chipselect & ~write_n;
    assign w_wr_ctrl   = w_wr && (address == 2'd0);
    assign w_wr_status = w_wr && (address == 2'd1);

    // HOLD acts on the edge it is written, so a CTRL write that sets HOLD
    // overrides a START carried in the same write.
    assign w_hold_nxt = w_wr_ctrl ? writedata[1] : r_hold;
    assign w_start    = w_wr_ctrl && writedata[0] && (r_state == ST_IDLE);

    // A length of 0 behaves like 1 so every phase lasts at least one cycle.
    assign w_assert_load  = (r_assert_len  == '0) ? '0 : r_assert_len  - CNT_ONE;
    assign w_recover_load = (r_recover_len == '0) ? '0 : r_recover_len - CNT_ONE;

    assign w_assert_len_ext  = 32'(r_assert_len);
    assign w_recover_len_ext = 32'(r_recover_len);
    assign w_unused_wdata    = ^writedata;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_set  = 1'b0;
        if (w_hold_nxt) begin
            w_state_nxt = ST_HOLD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        w_state_nxt = ST_ASSERT;
                        w_cnt_nxt   = w_assert_load;
                    end
                end
                ST_ASSERT: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_RECOVER;
                        w_cnt_nxt   = w_recover_load;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                ST_RECOVER: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_done_set  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    // Hold just released: run a full recovery.
                    w_state_nxt = ST_RECOVER;
                    w_cnt_nxt   = w_recover_load;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RST;
            r_cnt       <= CNT_RST;
            r_usb_rst_n <= (AUTO_ON_RESET != 0) ? 1'b0 : 1'b1;
            r_busy      <= (AUTO_ON_RESET != 0) ? 1'b1 : 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_usb_rst_n <= !((w_state_nxt == ST_ASSERT) || (w_state_nxt == ST_HOLD));
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold        <= 1'b0;
            r_done        <= 1'b0;
            r_assert_len  <= ASSERT_RST;
            r_recover_len <= RECOVER_RST;
        end else begin
            r_hold <= w_hold_nxt;
            // Completion beats a same-edge software clear.
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_start || (w_wr_status && writedata[2])) begin
                r_done <= 1'b0;
            end
            if (w_wr && address == 2'd2) begin
                r_assert_len <= writedata[CNT_W-1:0];
            end
            if (w_wr && address == 2'd3) begin
                r_recover_len <= writedata[CNT_W-1:0];
            end
        end
    end

`ifdef USB_RST_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en <= writedata[3];
            end
            r_irq <= r_done & r_irq_en;
        end
    end

    assign irq         = r_irq;
    assign w_irq_en_rd = r_irq_en;
`else
    assign w_irq_en_rd = 1'b0;
`endif

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = {28'd0, w_irq_en_rd, r_done, r_hold, r_busy};
            2'd1:    readdata = {29'd0, r_done, r_state};
            2'd2:    readdata = w_assert_len_ext;
            default: readdata = w_recover_len_ext;
        endcase
    end

    assign usb_rst_n = r_usb_rst_n;
    assign busy      = r_busy;

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// tb/tb_usb_rst_sequencer.sv - self-checking bench for usb_rst_sequencer

module tb_usb_rst_sequencer;

    localparam int CNT_W = 24;
    localparam int AC    = 4;
    localparam int RC    = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  m_addr = 2'd0;
    logic        m_cs = 1'b0;
    logic        m_wn = 1'b1;
    logic [31:0] m_wd = 32'd0;
    logic [31:0] m_rd;
    logic        m_rst_n;
    logic        m_busy;

    logic [1:0]  a_addr = 2'd0;
    logic        a_cs = 1'b0;
    logic        a_wn = 1'b1;
    logic [31:0] a_wd = 32'd0;
    logic [31:0] a_rd;
    logic        a_rst_n;
    logic        a_busy;

`ifdef USB_RST_IRQ_EN
    logic m_irq;
    logic a_irq;
`endif

    usb_rst_sequencer #(
        .CNT_W(CNT_W), .ASSERT_CYCLES(AC), .RECOVER_CYCLES(RC), .AUTO_ON_RESET(0)
    ) u_man (
        .clk(clk), .reset_n(reset_n), .address(m_addr), .chipselect(m_cs),
        .write_n(m_wn), .writedata(m_wd), .readdata(m_rd), .usb_rst_n(m_rst_n),
`ifdef USB_RST_IRQ_EN
        .irq(m_irq),
`endif
        .busy(m_busy)
    );

    usb_rst_sequencer #(
        .CNT_W(CNT_W), .ASSERT_CYCLES(AC), .RECOVER_CYCLES(RC), .AUTO_ON_RESET(1)
    ) u_auto (
        .clk(clk), .reset_n(reset_n), .address(a_addr), .chipselect(a_cs),
        .write_n(a_wn), .writedata(a_wd), .readdata(a_rd), .usb_rst_n(a_rst_n),
`ifdef USB_RST_IRQ_EN
        .irq(a_irq),
`endif
        .busy(a_busy)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic wr, input logic [1:0] a, input logic [31:0] d);
        m_cs   = wr;
        m_wn   = !wr;
        m_addr = a;
        m_wd   = d;
        @(posedge clk);
        #1;
        m_cs = 1'b0;
        m_wn = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        m_addr = a;
        #1;
        d = m_rd;
    endtask

    task automatic rd_a(input logic [1:0] a, output logic [31:0] d);
        a_addr = a;
        #1;
        d = a_rd;
    endtask

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    // Expected state index from the time since a START, from the phase rules alone.
    function automatic int exp_state(input int j, input int ap, input int rp);
        if (j < ap)      return 1;
        if (j < ap + rp) return 2;
        return 0;
    endfunction

    logic [31:0] d;
    int sh_a, sh_r, ap, rp, act, v;
    logic [31:0] start_word;

    initial begin
`ifdef USB_RST_IRQ_EN
        start_word = 32'h9;
`else
        start_word = 32'h1;
`endif
        // Reset values for both modes.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_usb_rst_n", m_rst_n, 1);
        chk("rst_m_busy", m_busy, 0);
        chk("rst_a_usb_rst_n", a_rst_n, 0);
        chk("rst_a_busy", a_busy, 1);
        rd(2'd0, d); chk("rst_m_ctrl", d, 0);
        rd(2'd1, d); chk("rst_m_status", d, 0);
        rd(2'd2, d); chk("rst_m_assert_len", d, AC);
        rd(2'd3, d); chk("rst_m_recover_len", d, RC);
        rd_a(2'd1, d); chk("rst_a_status", d, 1);

        // Auto sequence after reset release.
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 2'd0, 32'd0);
            chk($sformatf("auto_k%0d_rst_n", k), a_rst_n, (k >= AC));
            chk($sformatf("auto_k%0d_busy", k), a_busy, (k < AC + RC));
        end
        rd_a(2'd0, d); chk("auto_ctrl_done", d, 32'h4);

        // ASSERT_LEN=0 behaves as 1; repeated START while busy is ignored.
        step(1'b1, 2'd2, 32'd0);
        step(1'b1, 2'd0, 32'd1);
        for (int j = 0; j <= 8; j++) begin
            chk($sformatf("len0_j%0d_rst_n", j), m_rst_n, (j >= 1));
            chk($sformatf("len0_j%0d_busy", j), m_busy, (j < 1 + RC));
            if (j <= 5) step(1'b1, 2'd0, 32'd1);
            else        step(1'b0, 2'd0, 32'd0);
        end
        rd(2'd0, d); chk("len0_ctrl_done", d, 32'h4);

        // Randomized sequences against the phase-timing model.
        sh_a = 0;
        sh_r = RC;
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                sh_a = $urandom_range(0, 7);
                sh_r = $urandom_range(0, 7);
                step(1'b1, 2'd2, sh_a);
                step(1'b1, 2'd3, sh_r);
            end
            ap = max1(sh_a);
            rp = max1(sh_r);
            step(1'b1, 2'd0, 32'd1);
            rd(2'd0, d); chk($sformatf("rnd%0d_ctrl_start", it), d, 32'h1);
            for (int j = 0; j <= ap + rp + 1; j++) begin
                chk($sformatf("rnd%0d_j%0d_rst_n", it, j), m_rst_n, (j >= ap));
                chk($sformatf("rnd%0d_j%0d_busy", it, j), m_busy, (j < ap + rp));
                rd(2'd1, d);
                chk($sformatf("rnd%0d_j%0d_state", it, j), d[1:0], exp_state(j, ap, rp));
                act = $urandom_range(0, 3);
                v   = $urandom_range(0, 7);
                if (act == 1) begin
                    sh_a = v;
                    step(1'b1, 2'd2, v);
                end else if (act == 2 && j < ap + rp) begin
                    step(1'b1, 2'd0, 32'd1);
                end else if (act == 3 && j >= ap) begin
                    sh_r = v;
                    step(1'b1, 2'd3, v);
                end else begin
                    step(1'b0, 2'd0, 32'd0);
                end
            end
            rd(2'd1, d); chk($sformatf("rnd%0d_done", it), d, 32'h4);
        end

        // HOLD mid-RECOVER, then release into a fresh RECOVER.
        step(1'b1, 2'd2, 32'd3);
        step(1'b1, 2'd3, 32'd6);
        step(1'b1, 2'd0, 32'd1);
        repeat (4) step(1'b0, 2'd0, 32'd0);
        rd(2'd1, d); chk("hold_pre_state", d, 32'h2);
        step(1'b1, 2'd0, 32'd2);
        chk("hold_rst_n", m_rst_n, 0);
        chk("hold_busy", m_busy, 1);
        rd(2'd1, d); chk("hold_status", d, 32'h3);
        rd(2'd0, d); chk("hold_ctrl", d, 32'h3);
        repeat (3) step(1'b0, 2'd0, 32'd0);
        rd(2'd1, d); chk("hold_stay", d, 32'h3);
        step(1'b1, 2'd0, 32'd0);
        for (int j = 0; j <= 7; j++) begin
            chk($sformatf("unhold_j%0d_rst_n", j), m_rst_n, 1);
            chk($sformatf("unhold_j%0d_busy", j), m_busy, (j < 6));
            step(1'b0, 2'd0, 32'd0);
        end
        rd(2'd1, d); chk("unhold_done", d, 32'h4);

        // START together with HOLD: no ASSERT phase.
        step(1'b1, 2'd0, 32'd3);
        rd(2'd1, d); chk("starthold_status", d, 32'h3);
        step(1'b1, 2'd0, 32'd0);
        rd(2'd1, d); chk("starthold_release", d, 32'h2);
        repeat (7) step(1'b0, 2'd0, 32'd0);
        chk("starthold_busy_end", m_busy, 0);

        // RECOVER_LEN written during ASSERT is used at RECOVER entry.
        step(1'b1, 2'd2, 32'd4);
        step(1'b1, 2'd3, 32'd6);
        step(1'b1, 2'd0, 32'd1);
        step(1'b1, 2'd3, 32'd2);
        for (int j = 1; j <= 7; j++) begin
            chk($sformatf("rlen_j%0d_rst_n", j), m_rst_n, (j >= 4));
            chk($sformatf("rlen_j%0d_busy", j), m_busy, (j < 6));
            step(1'b0, 2'd0, 32'd0);
        end

        // Done set and STATUS clear on the same edge.
        step(1'b1, 2'd2, 32'd1);
        step(1'b1, 2'd3, 32'd1);
        step(1'b1, 2'd0, start_word);
        step(1'b0, 2'd0, 32'd0);
        step(1'b1, 2'd1, 32'h4);
        rd(2'd1, d); chk("done_set_wins", d, 32'h4);
        step(1'b0, 2'd0, 32'd0);
`ifdef USB_RST_IRQ_EN
        chk("irq_follows_done", m_irq, 1);
        rd(2'd0, d); chk("ctrl_irq_en", d, 32'hC);
`else
        rd(2'd0, d); chk("ctrl_bit3_zero", d, 32'h4);
`endif
        step(1'b1, 2'd1, 32'h4);
        rd(2'd1, d); chk("done_cleared", d, 32'h0);
        step(1'b0, 2'd0, 32'd0);
`ifdef USB_RST_IRQ_EN
        chk("irq_cleared", m_irq, 0);
`endif

        // Asynchronous reset mid-ASSERT.
        step(1'b1, 2'd2, 32'd5);
        step(1'b1, 2'd0, 32'd1);
        step(1'b0, 2'd0, 32'd0);
        chk("arst_pre_rst_n", m_rst_n, 0);
        reset_n = 1'b0;
        #1;
        chk("arst_m_rst_n", m_rst_n, 1);
        chk("arst_m_busy", m_busy, 0);
        chk("arst_a_rst_n", a_rst_n, 0);
        chk("arst_a_busy", a_busy, 1);
        rd(2'd2, d); chk("arst_assert_len", d, AC);
        rd(2'd0, d); chk("arst_ctrl", d, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) step(1'b0, 2'd0, 32'd0);
        chk("arst_after_busy", m_busy, 0);
        chk("arst_after_a_busy", a_busy, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
